// File: rtl/sync_serial_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sync_serial_pkg
//  Purpose  : Shared types and defaults for the three-wire synchronous serial
//             link (data_clk / data_point / Enable). Used by both link ends.
//  Revision : 1.0  initial release
// ============================================================================
package sync_serial_pkg;

    // Width of the link FSM state encoding
    localparam int c_STATE_W = 3;

    // Default frame geometry: 8-bit words, data_clk = clk/4
    localparam int c_DEF_DATA_W  = 8;
    localparam int c_DEF_CLK_DIV = 2;

    // Link FSM states, shared so the receiver can mirror the frame phases
    typedef enum logic [c_STATE_W-1:0] {
        IDLE  = 3'd0,
        LEAD  = 3'd1,
        HIGH  = 3'd2,
        LOW   = 3'd3,
        TRAIL = 3'd4
    } state_t;

endpackage : sync_serial_pkg
`default_nettype wire

// File: rtl/sync_serial_tick.sv
`default_nettype none
// ============================================================================
//  Module   : sync_serial_tick
//  Purpose  : Half-period divider. Counts 0..CLK_DIV-1 and flags the last
//             cycle of each half-period. A synchronous clear restarts the
//             count so every FSM state lasts exactly CLK_DIV cycles.
//  Revision : 1.0  initial release
// ============================================================================
module sync_serial_tick
    import sync_serial_pkg::*;
#(
    parameter int CLK_DIV = c_DEF_CLK_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    // A 1-bit counter is kept for CLK_DIV=1 so the compare stays well formed
    localparam int                 c_CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(CLK_DIV - 1);

    logic [c_CNT_W-1:0] r_div_cnt;

    // Free-running half-period counter; wraps on tick, restarts on clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_div_cnt <= '0;
        end else if (clear || tick) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
        end
    end

    assign tick = (r_div_cnt == c_LAST);

endmodule : sync_serial_tick
`default_nettype wire

// File: rtl/sync_serial_tx.sv
`default_nettype none
// ============================================================================
//  Module   : sync_serial_tx
//  Purpose  : Transmit end of the synchronous serial link. Accepts a word on
//             a valid/ready handshake and serialises it on data_point with a
//             registered divided clock on data_clk; Enable brackets the frame.
//             Data only changes as data_clk falls, so the far end samples on
//             the rising edge.
//  Revision : 1.0  initial release
// ============================================================================
module sync_serial_tx
    import sync_serial_pkg::*;
#(
    parameter int DATA_W    = c_DEF_DATA_W,
    parameter int CLK_DIV   = c_DEF_CLK_DIV,
    parameter int MSB_FIRST = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              data_clk,
    output logic              data_point,
    output logic              Enable,
    output logic              busy,
    output logic              done
);

    localparam int                 c_CNT_W = $clog2(DATA_W + 1);
    localparam logic [c_CNT_W-1:0] c_BITS  = c_CNT_W'(DATA_W);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [DATA_W-1:0]   r_shift;
    logic [DATA_W-1:0]   w_shift_nxt;
    logic [DATA_W-1:0]   w_shift_adv;
    logic [c_CNT_W-1:0]  r_bit_cnt;
    logic [c_CNT_W-1:0]  w_bit_cnt_nxt;
    logic [c_CNT_W-1:0]  w_bit_cnt_dec;
    logic                w_tick;
    logic                w_accept;
    logic                w_more;
    logic                w_clear;
    logic                w_dp_nxt;

    logic                r_tx_ready;
    logic                r_data_clk;
    logic                r_data_point;
    logic                r_enable;
    logic                r_busy;
    logic                r_done;

    // Bit presented on the line for a given shift-register image
    function automatic logic head_bit(input logic [DATA_W-1:0] w);
        return (MSB_FIRST != 0) ? w[DATA_W-1] : w[0];
    endfunction

    // r_tx_ready mirrors (r_state == IDLE), so this is the handshake
    assign w_accept      = tx_valid & r_tx_ready;
    assign w_bit_cnt_dec = r_bit_cnt - 1'b1;
    assign w_more        = (w_bit_cnt_dec != '0);
    assign w_shift_adv   = (MSB_FIRST != 0) ? {r_shift[DATA_W-2:0], 1'b0}
                                            : {1'b0, r_shift[DATA_W-1:1]};

    // Divider restarts on accept and on every state change
    assign w_clear = w_accept | (w_state_nxt != r_state);

    sync_serial_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk   (clk),
        .rst   (rst),
        .clear (w_clear),
        .tick  (w_tick)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: every non-IDLE state is left on tick
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = LEAD;
            LEAD:    if (w_tick)   w_state_nxt = HIGH;
            HIGH:    if (w_tick)   w_state_nxt = w_more ? LOW : TRAIL;
            LOW:     if (w_tick)   w_state_nxt = HIGH;
            TRAIL:   if (w_tick)   w_state_nxt = IDLE;
            default:               w_state_nxt = IDLE;
        endcase
    end

    // Datapath next values: load on accept, shift as data_clk falls into LOW,
    // clear the line as the frame closes
    always_comb begin
        w_shift_nxt   = r_shift;
        w_bit_cnt_nxt = r_bit_cnt;
        w_dp_nxt      = r_data_point;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_shift_nxt   = tx_data;
                    w_bit_cnt_nxt = c_BITS;
                    w_dp_nxt      = head_bit(tx_data);
                end
            end
            HIGH: begin
                if (w_tick) begin
                    w_bit_cnt_nxt = w_bit_cnt_dec;
                    if (w_more) begin
                        w_shift_nxt = w_shift_adv;
                        w_dp_nxt    = head_bit(w_shift_adv);
                    end
                end
            end
            TRAIL: begin
                if (w_tick) w_dp_nxt = 1'b0;
            end
            default: ;
        endcase
    end

    // Datapath and output flops; outputs follow the state being entered
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_shift      <= '0;
            r_bit_cnt    <= '0;
            r_tx_ready   <= 1'b1;
            r_data_clk   <= 1'b0;
            r_data_point <= 1'b0;
            r_enable     <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_shift      <= w_shift_nxt;
            r_bit_cnt    <= w_bit_cnt_nxt;
            r_tx_ready   <= (w_state_nxt == IDLE);
            r_data_clk   <= (w_state_nxt == HIGH);
            r_data_point <= w_dp_nxt;
            r_enable     <= (w_state_nxt != IDLE);
            r_busy       <= (w_state_nxt != IDLE);
            r_done       <= (r_state == TRAIL) && w_tick;
        end
    end

    assign tx_ready   = r_tx_ready;
    assign data_clk   = r_data_clk;
    assign data_point = r_data_point;
    assign Enable     = r_enable;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule : sync_serial_tx
`default_nettype wire

// File: tb/tb_sync_serial_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sync_serial_tx
//  Purpose  : Directed bench for sync_serial_tx. Instance A uses defaults
//             (8 bits, CLK_DIV=2, MSB first); instance B uses CLK_DIV=1,
//             LSB first. Expected bits are queued when a word is accepted and
//             popped on each rising data_clk edge.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sync_serial_tx;

    logic       clk = 1'b1;
    logic       rst;

    logic [7:0] a_tx_data;
    logic       a_tx_valid;
    logic       a_tx_ready, a_data_clk, a_data_point, a_enable, a_busy, a_done;

    logic [7:0] b_tx_data;
    logic       b_tx_valid;
    logic       b_tx_ready, b_data_clk, b_data_point, b_enable, b_busy, b_done;

    int total = 0;
    int bad   = 0;

    bit q_a[$];
    bit q_b[$];

    // Monitor state, instance A
    bit a_prev_dclk = 0, a_prev_en = 0;
    int a_run_en = 0, a_run_edges = 0, a_run_low = 0;
    int a_last_en = 0, a_last_edges = 0, a_last_low = 0;
    int a_done_cnt = 0;

    // Monitor state, instance B
    bit b_prev_dclk = 0, b_prev_en = 0;
    int b_run_en = 0, b_run_edges = 0;
    int b_last_en = 0, b_last_edges = 0;

    always #5 clk = ~clk;

    sync_serial_tx #(
        .DATA_W    (8),
        .CLK_DIV   (2),
        .MSB_FIRST (1)
    ) u_dut_a (
        .clk        (clk),
        .rst        (rst),
        .tx_data    (a_tx_data),
        .tx_valid   (a_tx_valid),
        .tx_ready   (a_tx_ready),
        .data_clk   (a_data_clk),
        .data_point (a_data_point),
        .Enable     (a_enable),
        .busy       (a_busy),
        .done       (a_done)
    );

    sync_serial_tx #(
        .DATA_W    (8),
        .CLK_DIV   (1),
        .MSB_FIRST (0)
    ) u_dut_b (
        .clk        (clk),
        .rst        (rst),
        .tx_data    (b_tx_data),
        .tx_valid   (b_tx_valid),
        .tx_ready   (b_tx_ready),
        .data_clk   (b_data_clk),
        .data_point (b_data_point),
        .Enable     (b_enable),
        .busy       (b_busy),
        .done       (b_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Instance A: sample the line on every rising data_clk, track frame stats
    always @(negedge clk) begin
        if (!rst) begin
            a_prev_dclk = 0; a_prev_en = 0;
            a_run_en = 0; a_run_edges = 0; a_run_low = 0;
        end else begin
            if (a_data_clk && !a_prev_dclk) begin
                a_run_edges++;
                if (q_a.size() == 0) begin
                    check("a_unexpected_edge", 32'd1, 32'd0);
                end else begin
                    check("a_bit", {31'd0, a_data_point}, {31'd0, q_a.pop_front()});
                end
            end
            if (a_enable) begin
                if (!a_prev_en) begin
                    a_last_low = a_run_low;
                    a_run_low  = 0;
                end
                a_run_en++;
            end else begin
                if (a_prev_en) begin
                    a_last_en    = a_run_en;
                    a_last_edges = a_run_edges;
                    a_run_en     = 0;
                    a_run_edges  = 0;
                end
                a_run_low++;
            end
            if (a_done) a_done_cnt++;
            a_prev_dclk = a_data_clk;
            a_prev_en   = a_enable;
        end
    end

    // Instance B: same sampling, bits and frame length only
    always @(negedge clk) begin
        if (!rst) begin
            b_prev_dclk = 0; b_prev_en = 0; b_run_en = 0; b_run_edges = 0;
        end else begin
            if (b_data_clk && !b_prev_dclk) begin
                b_run_edges++;
                if (q_b.size() == 0) begin
                    check("b_unexpected_edge", 32'd1, 32'd0);
                end else begin
                    check("b_bit", {31'd0, b_data_point}, {31'd0, q_b.pop_front()});
                end
            end
            if (b_enable) begin
                b_run_en++;
            end else if (b_prev_en) begin
                b_last_en    = b_run_en;
                b_last_edges = b_run_edges;
                b_run_en     = 0;
                b_run_edges  = 0;
            end
            b_prev_dclk = b_data_clk;
            b_prev_en   = b_enable;
        end
    end

    // One cycle, landing just after the falling edge (monitors already ran)
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Offer a word to A; expected bits are queued MSB first on acceptance
    task automatic send_a(input logic [7:0] w, input bit keep);
        int n = 0;
        a_tx_data  = w;
        a_tx_valid = 1'b1;
        while (!a_tx_ready && n < 200) begin
            step();
            n++;
        end
        check("a_accept_in_time", {31'd0, (n < 200)}, 32'd1);
        for (int i = 7; i >= 0; i--) q_a.push_back(w[i]);
        step();
        if (!keep) a_tx_valid = 1'b0;
    endtask

    // Offer a word to B; expected bits are queued LSB first on acceptance
    task automatic send_b(input logic [7:0] w);
        int n = 0;
        b_tx_data  = w;
        b_tx_valid = 1'b1;
        while (!b_tx_ready && n < 200) begin
            step();
            n++;
        end
        check("b_accept_in_time", {31'd0, (n < 200)}, 32'd1);
        for (int i = 0; i < 8; i++) q_b.push_back(w[i]);
        step();
        b_tx_valid = 1'b0;
    endtask

    task automatic wait_done_a(input string tag);
        int n = 0;
        while (!a_done && n < 200) begin
            step();
            n++;
        end
        check(tag, {31'd0, (n < 200)}, 32'd1);
    endtask

    task automatic wait_done_b(input string tag);
        int n = 0;
        while (!b_done && n < 200) begin
            step();
            n++;
        end
        check(tag, {31'd0, (n < 200)}, 32'd1);
    endtask

    initial begin
        int d0;
        int n;
        rst        = 1'b0;
        a_tx_data  = '0;
        a_tx_valid = 1'b0;
        b_tx_data  = '0;
        b_tx_valid = 1'b0;

        // ---- 1: reset values, then idle handshake state
        #12;
        check("rst_data_clk",   {31'd0, a_data_clk},   32'd0);
        check("rst_data_point", {31'd0, a_data_point}, 32'd0);
        check("rst_enable",     {31'd0, a_enable},     32'd0);
        check("rst_busy",       {31'd0, a_busy},       32'd0);
        check("rst_done",       {31'd0, a_done},       32'd0);
        #3 rst = 1'b1;
        step();
        check("idle_tx_ready", {31'd0, a_tx_ready}, 32'd1);
        check("idle_busy",     {31'd0, a_busy},     32'd0);
        check("idle_b_ready",  {31'd0, b_tx_ready}, 32'd1);

        // ---- 2: single A5 frame
        d0 = a_done_cnt;
        send_a(8'hA5, 1'b0);
        check("a5_busy", {31'd0, a_busy}, 32'd1);
        wait_done_a("a5_done_seen");
        step();
        check("a5_done_one_cycle", {31'd0, a_done},  32'd0);
        check("a5_enable_len",     a_last_en,        32'd34);
        check("a5_edges",          a_last_edges,     32'd8);
        check("a5_done_count",     a_done_cnt - d0,  32'd1);
        check("a5_queue_empty",    q_a.size(),       32'd0);
        check("a5_idle_ready",     {31'd0, a_tx_ready}, 32'd1);

        // ---- 3: a 3C pulse mid-frame is ignored
        send_a(8'hA5, 1'b0);
        repeat (5) step();
        a_tx_data  = 8'h3C;
        a_tx_valid = 1'b1;
        check("busy_ready_low", {31'd0, a_tx_ready}, 32'd0);
        step();
        a_tx_valid = 1'b0;
        check("busy_ready_still_low", {31'd0, a_tx_ready}, 32'd0);
        wait_done_a("ignore_done_seen");
        step();
        check("ignore_enable_len", a_last_en,    32'd34);
        check("ignore_edges",      a_last_edges, 32'd8);
        check("ignore_queue",      q_a.size(),   32'd0);
        repeat (3) step();
        check("ignore_no_frame", {31'd0, a_enable}, 32'd0);

        // ---- 4: back-to-back A5 then 3C with valid held
        send_a(8'hA5, 1'b1);
        send_a(8'h3C, 1'b0);
        check("b2b_gap", a_last_low, 32'd1);
        wait_done_a("b2b_done_seen");
        step();
        check("b2b_enable_len", a_last_en,    32'd34);
        check("b2b_edges",      a_last_edges, 32'd8);
        check("b2b_queue",      q_a.size(),   32'd0);

        // ---- 5: reset after the 3rd rising edge aborts without done
        d0 = a_done_cnt;
        send_a(8'hA5, 1'b0);
        n = 0;
        while (a_run_edges < 3 && n < 200) begin
            step();
            n++;
        end
        check("abort_edge3_seen", {31'd0, (n < 200)}, 32'd1);
        rst = 1'b0;
        #1;
        check("abort_data_clk",   {31'd0, a_data_clk},   32'd0);
        check("abort_data_point", {31'd0, a_data_point}, 32'd0);
        check("abort_enable",     {31'd0, a_enable},     32'd0);
        check("abort_busy",       {31'd0, a_busy},       32'd0);
        check("abort_done",       {31'd0, a_done},       32'd0);
        step();
        step();
        rst = 1'b1;
        q_a.delete();
        repeat (40) step();
        check("abort_no_done", a_done_cnt - d0, 32'd0);
        send_a(8'hFF, 1'b0);
        wait_done_a("ff_done_seen");
        step();
        check("ff_enable_len", a_last_en,    32'd34);
        check("ff_edges",      a_last_edges, 32'd8);
        check("ff_queue",      q_a.size(),   32'd0);

        // ---- 6: LSB first, CLK_DIV=1, word 01
        send_b(8'h01);
        wait_done_b("b01_done_seen");
        step();
        check("b01_enable_len", b_last_en,    32'd17);
        check("b01_edges",      b_last_edges, 32'd8);
        check("b01_queue",      q_b.size(),   32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_sync_serial_tx
`default_nettype wire
